// File: rtl/spi_dec_pkg.sv
// Shared types and helpers for the SPI burst decoder: FSM state encoding,
// command word field positions and the register range check.
package spi_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

  // R/nW is the top bit of the command word: index WORD_W - RNW_OFS
  localparam int RNW_OFS      = 1;
  // command address field starts at this bit and is ADDR_W wide
  localparam int CMD_ADDR_LSB = 0;

  function automatic logic addr_ok(input int unsigned addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/spi_word_deser.sv
// MSB-first serial-to-parallel word assembler framed by cs_n; word_done is
// combinational on the edge that will capture the last bit of a word.
module spi_word_deser #(
  parameter int WORD_W = 8
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              cs_n,
  input  logic              mosi,
  output logic [WORD_W-1:0] word,
  output logic              word_done,
  output logic              frame_clr
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;

  assign frame_clr = cs_n;
  assign word      = {shreg_q[WORD_W-2:0], mosi};
  assign word_done = !cs_n && (bitcnt_q == CNT_W'(WORD_W-1));

  always_comb begin
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (cs_n) begin
      // frame end drops any partial word
      shreg_d  = '0;
      bitcnt_d = '0;
    end else begin
      shreg_d  = word;
      bitcnt_d = word_done ? '0 : bitcnt_q + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

endmodule

// File: rtl/spi_burst_decoder.sv
// SPI command/burst decoder: first word of a frame is R/nW + start address,
// following words are register writes or read-address advances.
// Define SPI_BURST_EN for auto-increment bursts; otherwise one access per frame.
module spi_burst_decoder
  import spi_dec_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 16
) (
  input  logic              rstn,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_strobe,
  output logic              addr_err,
  output logic              busy
);

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic [WORD_W-1:0] word;
  logic              word_done, frame_clr;

  spi_word_deser #(.WORD_W(WORD_W)) u_deser (
    .sclk      (sclk),
    .rstn      (rstn),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .word      (word),
    .word_done (word_done),
    .frame_clr (frame_clr)
  );

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d, rd_strobe_q, rd_strobe_d, addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_ptr_q, wr_ptr_d, rd_addr_q, rd_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W:0]   wr_next, rd_next;

  assign cmd_addr = word[CMD_ADDR_LSB +: ADDR_W];
  // one extra bit so the last-register increment cannot wrap before the check
  assign wr_next  = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
  assign rd_next  = {1'b0, rd_addr_q} + (ADDR_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    rd_strobe_d = 1'b0;
    addr_err_d  = addr_err_q;
    wr_addr_d   = wr_addr_q;
    wr_ptr_d    = wr_ptr_q;
    wr_data_d   = wr_data_q;
    rd_addr_d   = rd_addr_q;
    if (frame_clr) begin
      state_d    = ST_IDLE;
      addr_err_d = 1'b0;
    end else if (word_done) begin
      case (state_q)
        ST_IDLE: begin
          if (!addr_ok(32'(cmd_addr), NUM_REGS)) begin
            state_d    = ST_DROP;
            addr_err_d = 1'b1;
          end else if (word[WORD_W-RNW_OFS]) begin
            rd_addr_d   = cmd_addr;
            rd_strobe_d = 1'b1;
            state_d     = BURST ? ST_READ : ST_DROP;
          end else begin
            wr_addr_d = cmd_addr;
            wr_ptr_d  = cmd_addr;
            state_d   = ST_WRITE;
          end
        end
        ST_WRITE: begin
          // wr_ptr is the next target; wr_addr shows the address being written
          wr_en_d   = 1'b1;
          wr_data_d = word;
          wr_addr_d = wr_ptr_q;
          if (!BURST) begin
            state_d = ST_DROP;
          end else begin
            wr_ptr_d = wr_next[ADDR_W-1:0];
            if (!addr_ok(32'(wr_next), NUM_REGS)) begin
              state_d    = ST_DROP;
              addr_err_d = 1'b1;
            end
          end
        end
        ST_READ: begin
          if (addr_ok(32'(rd_next), NUM_REGS)) begin
            rd_addr_d   = rd_next[ADDR_W-1:0];
            rd_strobe_d = 1'b1;
          end else begin
            state_d    = ST_DROP;
            addr_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      rd_strobe_q <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_ptr_q    <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_strobe_q <= rd_strobe_d;
      addr_err_q  <= addr_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_data_q   <= wr_data_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_addr   = rd_addr_q;
  assign rd_strobe = rd_strobe_q;
  assign addr_err  = addr_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_burst_decoder.sv
// Scoreboard bench for spi_burst_decoder: each scenario queues the strobes it
// expects and a posedge monitor pops and compares them as the DUT emits them.
module tb_spi_burst_decoder;

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    bit         is_wr;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic       rstn, sclk, cs_n, mosi;
  logic       wr_en, rd_strobe, addr_err, busy;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  spi_burst_decoder #(.WORD_W(8), .ADDR_W(7), .NUM_REGS(16)) dut (
    .rstn      (rstn),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_strobe (rd_strobe),
    .addr_err  (addr_err),
    .busy      (busy)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // monitor: every strobe must match the head of the scoreboard
  always @(posedge sclk) begin
    ev_t e;
    #1;
    if (wr_en === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_strobe: unexpected write addr=%0d data=%02h, none required", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (!e.is_wr || wr_addr !== e.addr || wr_data !== e.data) begin
          n_fail++;
          $display("FAIL wr_strobe: got write addr=%0d data=%02h, required %s addr=%0d data=%02h",
                   wr_addr, wr_data, e.is_wr ? "write" : "read", e.addr, e.data);
        end
      end
    end
    if (rd_strobe === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_strobe: unexpected read addr=%0d, none required", rd_addr);
      end else begin
        e = exp_q.pop_front();
        if (e.is_wr || rd_addr !== e.addr) begin
          n_fail++;
          $display("FAIL rd_strobe: got read addr=%0d, required %s addr=%0d",
                   rd_addr, e.is_wr ? "write" : "read", e.addr);
        end
      end
    end
  end

  task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [6:0] a);
    ev_t e;
    e.is_wr = 1'b0; e.addr = a; e.data = 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge sclk);
      cs_n = 1'b0;
      mosi = w[i];
    end
  endtask

  // close a frame: check sticky error and busy before cs_n rises, then the cleanup
  task automatic end_frame(input string name, input logic exp_err, input logic exp_busy);
    @(negedge sclk);
    n_tests++;
    if (addr_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s addr_err: got %b required %b", name, addr_err, exp_err);
    end
    n_tests++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL %s busy_in_frame: got %b required %b", name, busy, exp_busy);
    end
    cs_n = 1'b1;
    mosi = 1'b0;
    @(negedge sclk);
    @(negedge sclk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_strobes: got %0d outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
    n_tests++;
    if (addr_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s frame_end: got addr_err=%b busy=%b required 0 0", name, addr_err, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #3;
    n_tests++;
    if ({wr_en, wr_addr, wr_data, rd_addr, rd_strobe, addr_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got en=%b wa=%0d wd=%02h ra=%0d rs=%b err=%b busy=%b required all 0",
               wr_en, wr_addr, wr_data, rd_addr, rd_strobe, addr_err, busy);
    end
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    @(negedge sclk);
  endtask

  task automatic test_burst_write();
    push_wr(7'd3, 8'hA5);
    if (BURST) push_wr(7'd4, 8'h5A);
    send_bits(8'h03, 8); send_bits(8'hA5, 8); send_bits(8'h5A, 8);
    end_frame("burst_write", 1'b0, 1'b1);
    n_tests++;
    if (wr_addr !== (BURST ? 7'd4 : 7'd3) || wr_data !== (BURST ? 8'h5A : 8'hA5)) begin
      n_fail++;
      $display("FAIL burst_write hold: got addr=%0d data=%02h required addr=%0d data=%02h",
               wr_addr, wr_data, BURST ? 4 : 3, BURST ? 8'h5A : 8'hA5);
    end
  endtask

  task automatic test_burst_read();
    push_rd(7'd5);
    if (BURST) begin push_rd(7'd6); push_rd(7'd7); end
    send_bits(8'h85, 8); send_bits(8'h00, 8); send_bits(8'h00, 8);
    end_frame("burst_read", 1'b0, 1'b1);
    n_tests++;
    if (rd_addr !== (BURST ? 7'd7 : 7'd5)) begin
      n_fail++;
      $display("FAIL burst_read hold: got rd_addr=%0d required %0d", rd_addr, BURST ? 7 : 5);
    end
  endtask

  task automatic test_range_edge();
    push_wr(7'd15, 8'h11);
    send_bits(8'h0F, 8); send_bits(8'h11, 8); send_bits(8'h22, 8);
    end_frame("range_last_reg", BURST, 1'b1);
    send_bits(8'h10, 8);
    end_frame("range_cmd_oob", 1'b1, 1'b1);
    send_bits(8'h90, 8); send_bits(8'h33, 8);
    end_frame("range_rd_cmd_oob", 1'b1, 1'b1);
  endtask

  task automatic test_aborted_word();
    send_bits(8'hB3, 5);
    end_frame("aborted_partial", 1'b0, 1'b0);
    push_wr(7'd2, 8'h77);
    send_bits(8'h02, 8); send_bits(8'h77, 8);
    end_frame("aborted_next", 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    push_wr(7'd1, 8'h11);
    send_bits(8'h01, 8); send_bits(8'h11, 8); send_bits(8'h22, 3);
    #2 rstn = 1'b0;
    #1;
    n_tests++;
    if ({wr_en, wr_addr, wr_data, rd_addr, rd_strobe, addr_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_burst: got en=%b wa=%0d wd=%02h ra=%0d rs=%b err=%b busy=%b required all 0",
               wr_en, wr_addr, wr_data, rd_addr, rd_strobe, addr_err, busy);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_burst pre_strobes: got %0d outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge sclk);
    cs_n = 1'b1;
    repeat (2) @(negedge sclk);
    rstn = 1'b1;
    @(negedge sclk);
    push_wr(7'd1, 8'hC3);
    send_bits(8'h01, 8); send_bits(8'hC3, 8);
    end_frame("reset_resume", 1'b0, 1'b1);
  endtask

  task automatic test_single_access();
    push_wr(7'd1, 8'hAA);
    if (BURST) push_wr(7'd2, 8'hBB);
    send_bits(8'h01, 8); send_bits(8'hAA, 8); send_bits(8'hBB, 8);
    end_frame("single_access", 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    push_wr(7'd14, 8'h01);
    if (BURST) push_wr(7'd15, 8'h02);
    send_bits(8'h0E, 8); send_bits(8'h01, 8); send_bits(8'h02, 8);
    end_frame("b2b_write", BURST, 1'b1);
    push_rd(7'd15);
    send_bits(8'h8F, 8); send_bits(8'hFF, 8);
    end_frame("b2b_read_last", BURST, 1'b1);
  endtask

  initial begin
    test_reset();
    test_burst_write();
    test_burst_read();
    test_range_edge();
    test_aborted_word();
    test_reset_mid_burst();
    test_single_access();
    test_back_to_back();
    repeat (3) @(negedge sclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_burst_decoder.md
# spi_burst_decoder

Parametrised successor to the 8-bit serial write path. Deserialises MOSI on `sclk` into `WORD_W`-bit words, framed by chip-select. It decodes the first word of each frame as a read/write command with a start address. Subsequent words become auto-incrementing register writes, or advance the read address that drives the POCI mux. Range checking and burst control are included.

## Interface
- `WORD_W`, 8: bits per serial word; the command word is also `WORD_W` bits.
- `ADDR_W`, 7: address width; must satisfy `ADDR_W <= WORD_W-1`.
- `NUM_REGS`, 16: number of implemented registers; must satisfy `NUM_REGS <= 2**ADDR_W`.
- `rstn  in  1`: reset, asynchronous, active-low.
- `sclk  in  1`: clock; SPI clock, sampled on the rising edge.
- `cs_n  in  1`: frame select, active-low, sampled synchronously on `sclk`.
- `mosi  in  1`: serial data, MSB first.
- `wr_en  out  1`: one-cycle write strobe.
- `wr_addr  out  ADDR_W`: write address.
- `wr_data  out  WORD_W`: write data.
- `rd_addr  out  ADDR_W`: read address; drives the POCI mux select.
- `rd_strobe  out  1`: one-cycle pulse whenever `rd_addr` is loaded or advanced.
- `addr_err  out  1`: address out of range in the current frame; sticky until the frame ends.
- `busy  out  1`: high while the decoder is in WRITE, READ or DROP.

## Operation
- **Deserialiser**
  - Shifts `mosi` into `shreg` on each `sclk` rise while `cs_n` is low.
  - `bitcnt` counts from 0 to `WORD_W-1`.
  - The word is complete on the edge where `bitcnt == WORD_W-1`. The assembled word is `{shreg[WORD_W-2:0], mosi}`, and `bitcnt` returns to 0.
- **State machine:** IDLE, WRITE, READ, DROP.
- **IDLE, command word completes:**
  - Bit `WORD_W-1` is R/nW; the low `ADDR_W` bits are `cmd_addr`.
  - If `cmd_addr >= NUM_REGS`: go to DROP and set `addr_err`.
  - Else if R = 1: load `rd_addr <= cmd_addr`, pulse `rd_strobe`, go to READ.
  - Else: load `wr_addr <= cmd_addr`, go to WRITE.
- **WRITE, data word completes:**
  - Load `wr_data <= word` and pulse `wr_en` at the current `wr_addr`.
  - Then increment `wr_addr`.
  - If the incremented address reaches `NUM_REGS`, go to DROP and set `addr_err`. The address does not wrap.
- **READ, word completes:**
  - The MOSI content is ignored.
  - If `rd_addr + 1 < NUM_REGS`: increment `rd_addr` and pulse `rd_strobe`.
  - Else: go to DROP and set `addr_err`; `rd_addr` holds.
- **DROP:** all further words in the frame are ignored; there are no strobes.
- **Frame end (`cs_n` high at an `sclk` rise):**
  - Clear `bitcnt` and `shreg`, and discard any partial word.
  - Go to IDLE and clear `addr_err`.
  - Clear `wr_en` and `rd_strobe`.
  - `wr_addr`, `wr_data` and `rd_addr` hold their values.
- **Simultaneous events:** if `cs_n` is high on the edge that would complete a word, that word is discarded.
- **Arithmetic:** address increments are `ADDR_W` bits wide; the comparison against `NUM_REGS` is done at `ADDR_W+1` bits, so there is no overflow.

## Timing
- **Reset values:** all outputs 0, state IDLE, `bitcnt` 0, `shreg` 0.
- **Reset mid-frame:** `rstn` low aborts immediately and asynchronously. Decoding resumes on the first completed command word after release.
- **Write strobe:** `wr_en`, `wr_addr` and `wr_data` are registered. They are valid from the edge that completes a data word until the next `sclk` rise. `wr_en` is exactly one `sclk` cycle wide.
- **Read strobe:** `rd_addr` and `rd_strobe` are valid from the completing edge. The POCI side has `WORD_W` bit-times to shift out the selected register.
- **Latency:** from the last bit of a word to its strobe is 0 cycles; the strobe is registered on that same edge.
- **Clock stop:** `sclk` stops between frames. Frame-end cleanup takes effect on the first `sclk` edge seen with `cs_n` high; outputs hold until then.

## Configuration
- **`SPI_BURST_EN` defined:** auto-increment bursts as described above.
- **`SPI_BURST_EN` undefined:**
  - After the first data word in WRITE, or after the command in READ, the decoder enters DROP.
  - Exactly one access is made per frame, and there are no address increments.
  - `addr_err` is raised only by an out-of-range `cmd_addr`.

## Structure
- **Package `spi_dec_pkg`:**
  - State enum (IDLE, WRITE, READ, DROP).
  - Local parameters for the R/nW bit index and the command address field slice.
  - A function for the range check.
- **Sub-module `spi_word_deser`:** shift register plus bit counter. Outputs are `word`, `word_done` (combinational, on the completing edge) and the frame-abort clear.
- **Top level:** instantiates the deserialiser and holds the state machine and output registers.

## Test plan
Each scenario uses `WORD_W` = 8, `ADDR_W` = 7, `NUM_REGS` = 16.
- **Burst write:** frame 0x03, 0xA5, 0x5A → `wr_en` pulses twice, (addr 3, 0xA5) then (addr 4, 0x5A); `addr_err` stays 0.
- **Burst read:** frame 0x85, 0x00, 0x00 → `rd_addr` goes 5, then 6, then 7, with three `rd_strobe` pulses and no `wr_en`.
- **Range edge:** frame 0x0F, 0x11, 0x22 → write (15, 0x11); `addr_err` rises and 0x22 is not written. A frame with command 0x10 → `addr_err` with no strobes.
- **Aborted word:** `cs_n` rises after 5 bits; next frame 0x02, 0x77 → a single write (2, 0x77) and no spurious strobe.
- **Reset mid-burst:** `rstn` low during the second data word → all outputs 0 immediately; a following frame 0x01, 0xC3 writes (1, 0xC3).
- **`SPI_BURST_EN` undefined:** frame 0x01, 0xAA, 0xBB → only (1, 0xAA) is written; `busy` stays high until `cs_n` rises.
